// File: rtl/cannon_pkg.sv
// Shared types, defaults and index helpers for the Cannon matrix-multiply array.
package cannon_pkg;

  localparam int unsigned DEF_DW = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  // LSB position of element (r,c) in a row-major packed n x n matrix of dw-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                           input int unsigned n, input int unsigned dw);
    return (r * n + c) * dw;
  endfunction

  // The grid must tile the matrix exactly.
  function automatic bit grid_ok(input int unsigned n, input int unsigned q);
    return (q != 0) && ((n % q) == 0);
  endfunction

endpackage

// File: rtl/cannon_matmul_array_if.sv
// Operand/result bus of the Cannon matrix-multiply array.
interface cannon_matmul_array_if
  import cannon_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = DEF_DW
);
  localparam int unsigned MW = DW * N * N;

  logic          start;
  logic          acc_en;
  logic [MW-1:0] mat_a;
  logic [MW-1:0] mat_b;
  logic          busy;
  logic          done;
  logic [MW-1:0] mat_c;

  modport master (output start, acc_en, mat_a, mat_b, input busy, done, mat_c);
  modport slave  (input start, acc_en, mat_a, mat_b, output busy, done, mat_c);

endinterface

// File: rtl/block_mac_pe.sv
// One grid processing element: holds an A and a B block and accumulates their product.
module block_mac_pe #(
  parameter int unsigned BS = 2,
  parameter int unsigned DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DW*BS*BS-1:0]   a_load,
  input  logic [DW*BS*BS-1:0]   b_load,
  input  logic [DW*BS*BS-1:0]   a_in,
  input  logic [DW*BS*BS-1:0]   b_in,
  input  logic                  acc_clr,
  input  logic                  acc_pre,
  input  logic                  acc_add,
  input  logic [DW*BS*BS-1:0]   acc_pre_val,
  output logic [DW*BS*BS-1:0]   a_blk,
  output logic [DW*BS*BS-1:0]   b_blk,
  output logic [DW*BS*BS-1:0]   acc_next_c
);

  localparam int unsigned BW = DW * BS * BS;

  logic [BW-1:0] acc_q;

  // Block product plus current accumulator, each element a chain of BS wrapped MACs.
  for (genvar i = 0; i < BS; i++) begin : g_row
    for (genvar j = 0; j < BS; j++) begin : g_col
      logic [DW-1:0] part [BS+1];
      assign part[0] = acc_q[(i*BS+j)*DW +: DW];
      for (genvar k = 0; k < BS; k++) begin : g_k
        assign part[k+1] = part[k] + DW'(a_blk[(i*BS+k)*DW +: DW] * b_blk[(k*BS+j)*DW +: DW]);
      end
      assign acc_next_c[(i*BS+j)*DW +: DW] = part[BS];
    end
  end

  // Operand blocks: skewed load at start, torus shift-in while computing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_blk <= '0;
      b_blk <= '0;
    end else if (load) begin
      a_blk <= a_load;
      b_blk <= b_load;
    end else if (shift) begin
      a_blk <= a_in;
      b_blk <= b_in;
    end
  end

  // Accumulator: clear or preload at start, accumulate on each compute edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (acc_pre) begin
      acc_q <= acc_pre_val;
    end else if (acc_add) begin
      acc_q <= acc_next_c;
    end
  end

endmodule

// File: rtl/cannon_matmul_array.sv
// Q x Q Cannon-algorithm matrix multiplier: C = A*B or C += A*B, wrapping modulo 2^DW.
module cannon_matmul_array
  import cannon_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned Q  = 2,
  parameter int unsigned DW = DEF_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  cannon_matmul_array_if.slave   bus
);

  localparam int unsigned BS = N / Q;
  localparam int unsigned BW = DW * BS * BS;
  localparam int unsigned MW = DW * N * N;
  localparam int unsigned SW = (Q > 1) ? $clog2(Q) : 1;

  if (!grid_ok(N, Q)) begin : g_bad_grid
    $error("cannon_matmul_array: N must be a multiple of Q");
  end

  state_t        state_q, state_nxt;
  logic [SW-1:0] step_q, step_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic [MW-1:0] mat_c_q;
  logic [MW-1:0] c_new_c;
  logic          load_c, compute_c, last_c;
  logic          clr_c, pre_c;

  logic [BW-1:0] a_blk   [Q][Q];
  logic [BW-1:0] b_blk   [Q][Q];
  logic [BW-1:0] acc_nx  [Q][Q];

  // Control state, step counter and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      step_q  <= step_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state logic: accept start only in IDLE, run Q compute edges, pulse done.
  always_comb begin
    state_nxt = state_q;
    step_nxt  = step_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    load_c    = 1'b0;
    compute_c = 1'b0;
    last_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_c    = 1'b1;
          step_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        compute_c = 1'b1;
        if (step_q == SW'(Q - 1)) begin
          last_c    = 1'b1;
          step_nxt  = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          step_nxt = step_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_c = load_c & ~bus.acc_en;
  assign pre_c = load_c & bus.acc_en;

  // Grid: skewed block selection, torus neighbours, and result gather.
  for (genvar i = 0; i < Q; i++) begin : g_row
    for (genvar j = 0; j < Q; j++) begin : g_col
      localparam int unsigned KB = (i + j) % Q;

      logic [BW-1:0] a_ld_c, b_ld_c, c_pre_c;

      for (genvar r = 0; r < BS; r++) begin : g_r
        for (genvar c = 0; c < BS; c++) begin : g_c
          assign a_ld_c[(r*BS+c)*DW +: DW]  = bus.mat_a[elem_lsb(i*BS+r, KB*BS+c, N, DW) +: DW];
          assign b_ld_c[(r*BS+c)*DW +: DW]  = bus.mat_b[elem_lsb(KB*BS+r, j*BS+c, N, DW) +: DW];
          assign c_pre_c[(r*BS+c)*DW +: DW] = mat_c_q[elem_lsb(i*BS+r, j*BS+c, N, DW) +: DW];
          assign c_new_c[elem_lsb(i*BS+r, j*BS+c, N, DW) +: DW] = acc_nx[i][j][(r*BS+c)*DW +: DW];
        end
      end

      block_mac_pe #(.BS(BS), .DW(DW)) u_pe (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .shift       (compute_c),
        .a_load      (a_ld_c),
        .b_load      (b_ld_c),
        .a_in        (a_blk[i][(j+1)%Q]),
        .b_in        (b_blk[(i+1)%Q][j]),
        .acc_clr     (clr_c),
        .acc_pre     (pre_c),
        .acc_add     (compute_c),
        .acc_pre_val (c_pre_c),
        .a_blk       (a_blk[i][j]),
        .b_blk       (b_blk[i][j]),
        .acc_next_c  (acc_nx[i][j])
      );
    end
  end

  // Result register, written on the final compute edge and held between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_c_q <= '0;
    end else if (last_c) begin
      mat_c_q <= c_new_c;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.mat_c = mat_c_q;

endmodule
